// File: rtl/ce_tick_gen.sv
// Programmable clock-enable pulse generator: one-cycle ce every P clocks,
// free-running or as a counted burst, with divisor updates applied only on period boundaries.
module ce_tick_gen #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             ce,
    output logic             busy,
    output logic             burst_done,
    output logic             dbg_state
);

    // Handshake: a divisor transfers on any edge where cfg_valid && cfg_ready;
    // cfg_ready stays low until that divisor has been applied to div_r.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] per_m1;
    logic             pend_valid;
    logic             wrap;
    logic             go;
    logic             abort;
    logic             last_ce;
    logic             cfg_take;
    logic             apply;
    logic             ce_d;
    logic             done_d;
    logic             busy_d;

    // A divisor of 0 behaves like 1: wrap every cycle.
    assign per_m1   = (div_r == '0) ? '0 : div_r - ONE;
    assign wrap     = (state == RUN) && (cnt == per_m1);
    assign go       = (state == IDLE) && start && !stop;
    assign abort    = (state == RUN) && stop;
    assign last_ce  = wrap && !stop && (bcnt == ONE);
    assign cfg_take = cfg_valid && !pend_valid;
    assign apply    = pend_valid && ((state == IDLE) || (wrap && !stop));

    assign cfg_ready = !pend_valid;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !stop) state_nxt = RUN;
            end
            RUN: begin
                if (stop)         state_nxt = IDLE;
                else if (last_ce) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy stays high through the cycle carrying the final burst pulse.
    always_comb begin
        ce_d   = wrap && !stop;
        done_d = last_ce;
        busy_d = (state_nxt == RUN) || last_ce;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce         <= 1'b0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ce         <= ce_d;
            burst_done <= done_d;
            busy       <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            bcnt <= '0;
        end else if (go) begin
            cnt  <= '0;
            bcnt <= burst_len;
        end else if (abort) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
            if (bcnt != '0) bcnt <= bcnt - ONE;
        end else if (state == RUN) begin
            cnt <= cnt + ONE;
        end
    end

    // apply needs a held divisor and cfg_take needs an empty slot, so they never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r      <= DIV_RST;
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else if (apply) begin
            div_r      <= pend_div;
            pend_valid <= 1'b0;
        end else if (cfg_take) begin
            pend_div   <= cfg_div;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ce_tick_gen.sv
// Self-checking bench for ce_tick_gen: directed scenarios plus random traffic,
// compared against an absolute-time pulse schedule model.
module tb_ce_tick_gen;

    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] burst_len;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             ce;
    logic             busy;
    logic             burst_done;
    logic             dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // model state: pulses are scheduled at absolute cycle numbers
    int t      = 0;
    bit m_run  = 0;
    int m_div  = DEFAULT_DIV;
    bit m_pend = 0;
    int m_pdiv = 0;
    int m_next = 0;
    int m_rem  = 0;
    bit m_ce   = 0;
    bit m_done = 0;
    bit m_busy = 0;

    int seen_ce   = 0;
    int seen_done = 0;

    ce_tick_gen #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .burst_len (burst_len),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ce        (ce),
        .busy      (busy),
        .burst_done(burst_done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    function automatic int per(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_div  = DEFAULT_DIV;
        m_pend = 0;
        m_ce   = 0;
        m_done = 0;
        m_busy = 0;
    endtask

    task automatic model_step();
        bit had_pend;
        had_pend = m_pend;
        m_ce     = 0;
        m_done   = 0;
        t++;
        if (m_run) begin
            if (stop) begin
                m_run = 0;
            end else if (t == m_next) begin
                m_ce = 1;
                if (m_pend) begin
                    m_div  = m_pdiv;
                    m_pend = 0;
                end
                m_next = t + per(m_div);
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1;
                        m_run  = 0;
                    end
                end
            end
            m_busy = m_run || m_done;
        end else begin
            if (m_pend) begin
                m_div  = m_pdiv;
                m_pend = 0;
            end
            if (start && !stop) begin
                m_run  = 1;
                m_rem  = int'(burst_len);
                m_next = t + per(m_div);
            end
            m_busy = m_run;
        end
        if (cfg_valid && !had_pend) begin
            m_pend = 1;
            m_pdiv = int'(cfg_div);
        end
    endtask

    task automatic check_outputs();
        check_val("ce", 32'(ce), 32'(m_ce));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("burst_done", 32'(burst_done), 32'(m_done));
        check_val("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check_val("state", 32'(dbg_state), 32'(m_run));
    endtask

    task automatic drive_cycle(input logic s, input logic p, input int blen,
                               input int cd, input logic cv);
        @(negedge clk);
        start     = s;
        stop      = p;
        burst_len = CNT_W'(blen);
        cfg_div   = CNT_W'(cd);
        cfg_valid = cv;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        seen_ce   += int'(ce);
        seen_done += int'(burst_done);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Reset asserted away from any clock edge; outputs must clear immediately.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check_val("rst_ce", 32'(ce), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(burst_done), 32'd0);
        check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        burst_len = '0;
        cfg_div   = '0;
        cfg_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // free-run at the reset divisor
        seen_ce = 0;
        drive_cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle_cycles(13);
        check_val("t2_pulses", 32'(seen_ce), 32'd3);
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);

        // burst of 5 at divisor 3
        drive_cycle(1'b0, 1'b0, 0, 3, 1'b1);
        idle_cycles(1);
        seen_ce   = 0;
        seen_done = 0;
        drive_cycle(1'b1, 1'b0, 5, 0, 1'b0);
        idle_cycles(20);
        check_val("t3_pulses", 32'(seen_ce), 32'd5);
        check_val("t3_done", 32'(seen_done), 32'd1);

        // divisor 8, new divisor 2 offered mid-period
        drive_cycle(1'b0, 1'b0, 0, 8, 1'b1);
        idle_cycles(1);
        drive_cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle_cycles(2);
        drive_cycle(1'b0, 1'b0, 0, 2, 1'b1);
        seen_ce = 0;
        idle_cycles(11);
        check_val("t4_pulses", 32'(seen_ce), 32'd4);
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);

        // start+stop together in idle, then stop mid-burst
        drive_cycle(1'b1, 1'b1, 0, 0, 1'b0);
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);
        seen_done = 0;
        drive_cycle(1'b1, 1'b0, 10, 0, 1'b0);
        idle_cycles(5);
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);
        idle_cycles(10);
        check_val("t5_done", 32'(seen_done), 32'd0);

        // divisor 0 and 1 both mean a pulse every cycle
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
        idle_cycles(1);
        seen_ce = 0;
        drive_cycle(1'b1, 1'b0, 3, 0, 1'b0);
        idle_cycles(6);
        check_val("t6_burst3", 32'(seen_ce), 32'd3);
        drive_cycle(1'b0, 1'b0, 0, 1, 1'b1);
        idle_cycles(1);
        seen_ce = 0;
        drive_cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle_cycles(7);
        check_val("t6_free", 32'(seen_ce), 32'd7);
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);

        // reset while running with a divisor pending; default divisor must return
        drive_cycle(1'b1, 1'b0, 0, 6, 1'b1);
        idle_cycles(2);
        reset_mid();
        seen_ce = 0;
        drive_cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle_cycles(9);
        check_val("t1_pulses", 32'(seen_ce), 32'd2);
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_mid();
            end else begin
                drive_cycle(logic'($urandom_range(0, 3) == 0),
                            logic'($urandom_range(0, 24) == 0),
                            int'($urandom_range(0, 6)),
                            int'($urandom_range(0, 7)),
                            logic'($urandom_range(0, 3) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
